nios_processor_vis_out_fifo: RTL and testbench
==============================================

# nios_processor_vis_out_fifo

Avalon-MM write-side output port for the Nios II system: the processor pushes 32-bit visualizer words (bar heights or sample values) into a small FIFO, and downstream display logic drains them through a valid/ready stream. It complements the read-only ADC input ports, carrying data from the processor to hardware. Status, flush and a sticky overflow flag are exposed on the same slave.

## Interface
- DEPTH, 16: FIFO depth in words; power of two, 2..256.
- ADDR_W, 4: log2(DEPTH).
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon-MM word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write takes effect when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts the head word.

## Operation
- Register map:
  - addr 0: a write pushes writedata. Reads return 0.
  - addr 1: read returns status: bit0 empty, bit1 full, bits[8+ADDR_W:8] level (0..DEPTH), all other bits 0. A write with writedata[0]=1 flushes the FIFO; writedata[0]=0 has no effect.
  - addr 2: read returns the overflow flag in bit0. A write with writedata[0]=1 clears it.
  - addr 3: reads return 0; writes are ignored.
- Storage: DEPTH×32 register array, with rd_ptr and wr_ptr each ADDR_W bits wide (they wrap modulo DEPTH) and level ADDR_W+1 bits wide.
- Pop: occurs when out_valid=1 and out_ready=1.
- Push: occurs on a write to addr 0 when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
- A push attempt at level==DEPTH with no pop is dropped: data and pointers are unchanged, and overflow is set to 1.
- Simultaneous push and pop: both pointers advance and level is unchanged.
- Flush: rd_ptr, wr_ptr and level go to 0. Array contents are not cleared. Flush preempts a pop in the same cycle. A push can never coincide with a flush, since both need a write on the same bus cycle.
- Overflow is sticky. If a set event and a clear write coincide, set wins, but they cannot coincide on a single-port bus.
- out_valid = (level != 0). out_data = mem[rd_ptr] (combinational from registers). out_data is don't-care when out_valid=0.
- out_data must hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset (reset_n=0, asynchronous): readdata=0, pointers=0, level=0, overflow=0, out_valid=0. The array is not reset.
- readdata is registered every cycle from the address-decoded mux, with no read strobe. Read latency is one cycle after address is presented (fixed wait-states=1).
- readdata reflects status as it was before the current cycle's edge updates.
- Push at edge N: out_valid=1 and level updated after edge N.
- Pop at edge N: the next head word (or out_valid=0) is presented after edge N.
- Full throughput: one push and one pop per cycle, indefinitely.
- Reset asserted mid-stream: the FIFO empties immediately and out_valid drops asynchronously.

## Test plan
- Reset, then read addr 1 -> readdata=0x00000001 (empty, level 0); out_valid=0.
- Push 0xA0000001, 0xA0000002, 0xA0000003 with out_ready=0 -> status=0x00000300, out_data=0xA0000001. Then hold out_ready=1 -> words appear in order on three consecutive cycles, and out_valid drops after the third.
- Push 17 words into the DEPTH=16 FIFO with out_ready=0 -> status=0x00001002 (full, level 16), addr 2 reads 1, and the 17th word is never output. Write 1 to addr 2 -> reads 0.
- Fill to full, then hold out_ready=1 while writing 0xBEEF0000 in the same cycle -> push accepted, level stays 16, overflow stays 0, and 0xBEEF0000 emerges 16th.
- Push 5 words, write 1 to addr 1 -> status=0x00000001 and out_valid=0 next cycle. A subsequent push of 0x12345678 -> out_data=0x12345678.
- Push 16 words/pop 16 words, repeated for 3 laps with random out_ready -> pointer wrap is correct and order is preserved against a scoreboard model.

Source files
------------

// File: rtl/nios_processor_vis_out_fifo.sv
// Purpose : Avalon-MM slave that lets the Nios II push 32-bit visualizer words into a
//           FIFO drained by display logic over a valid/ready stream.
// Latency : a push is visible on out_valid/out_data after the write edge; readdata
//           has a fixed one-cycle read latency.
// Backpressure: out_ready=0 holds the head word. A push into a full FIFO with no
//           pop in the same cycle is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   address, chipselect, write_n  Avalon-MM slave control (word addressed)
//   writedata / readdata          slave write / registered read data
//   out_data, out_valid           FIFO head word and non-empty flag
//   out_ready                     downstream accepts the head word
//
// Register map:
//   0: write pushes writedata; reads 0
//   1: read {level[8+ADDR_W:8], full[1], empty[0]}; write bit0=1 flushes
//   2: read overflow[0]; write bit0=1 clears overflow
//   3: reads 0, writes ignored
module nios_processor_vis_out_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   level;
  logic              overflow;

  logic        bus_wr;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        pop_eff;
  logic        flush;
  logic        ovf_set;
  logic        ovf_clr;
  logic        empty;
  logic        full;
  logic [31:0] rd_mux;

  assign empty     = (level == '0);
  assign full      = (level == FULL_LEVEL);
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];

  assign bus_wr   = chipselect & ~write_n;
  assign push_req = bus_wr & (address == 2'd0);
  assign flush    = bus_wr & (address == 2'd1) & writedata[0];
  assign ovf_clr  = bus_wr & (address == 2'd2) & writedata[0];

  assign pop = out_valid & out_ready;
  // A flush discards the queue, so a pop that coincides with it is ignored.
  assign pop_eff = pop & ~flush;

  // When full, a push is still legal if a slot is freed by a pop in the same cycle.
  assign push    = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop_eff})
        2'b10:   level <= level + (ADDR_W + 1)'(1);
        2'b01:   level <= level - (ADDR_W + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Set has priority over clear should both ever occur together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd1: begin
        rd_mux[0]          = empty;
        rd_mux[1]          = full;
        rd_mux[8+ADDR_W:8] = level;
      end
      2'd2:    rd_mux[0] = overflow;
      default: rd_mux    = '0;
    endcase
  end

  // Registered every cycle with no read strobe: one fixed wait-state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_nios_processor_vis_out_fifo.sv
// Purpose : self-checking bench for nios_processor_vis_out_fifo against a queue model.
// Latency : inputs change 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: out_ready driven directed or randomly; the model tracks drops/overflow.
module tb_nios_processor_vis_out_fifo;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_q[$];
  bit          model_ovf = 1'b0;

  nios_processor_vis_out_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register view computed from the abstract queue/flag state.
  function automatic logic [31:0] model_rd(input logic [1:0] a);
    int sz = model_q.size();
    case (a)
      2'd1:    return 32'((sz == 0) ? 1 : 0) + 32'((sz == DEPTH) ? 2 : 0) + 32'(sz * 256);
      2'd2:    return model_ovf ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One clock with the current inputs; updates the model and checks all outputs.
  task automatic tick();
    int          sz       = model_q.size();
    bit          wr       = chipselect && !write_n;
    bit          pop      = (sz != 0) && out_ready;
    bit          do_flush = wr && (address == 2'd1) && writedata[0];
    bit          do_push  = wr && (address == 2'd0);
    bit          do_clr   = wr && (address == 2'd2) && writedata[0];
    logic [31:0] wd       = writedata;
    logic [31:0] exp_rd   = model_rd(address);
    @(posedge clk);
    #1;
    if (do_flush) begin
      model_q.delete();
    end else begin
      if (pop) model_q.delete(0);
      if (do_push) begin
        if (sz < DEPTH || pop) model_q.push_back(wd);
        else model_ovf = 1'b1;
      end
    end
    if (do_clr) model_ovf = 1'b0;
    check("readdata", readdata, exp_rd);
    check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check("out_data", out_data, model_q[0]);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    tick();
    chipselect = 1'b0;
    d          = readdata;
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    int          pos;

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    out_ready  = 1'b0;

    // Reset state
    #2;
    check("reset_readdata", readdata, 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    bus_read(2'd1, rd);
    check("status_after_reset", rd, 32'h0000_0001);
    check("valid_after_reset", 32'(out_valid), 32'd0);

    // Three pushes held, then drained on consecutive cycles
    bus_write(2'd0, 32'hA000_0001);
    bus_write(2'd0, 32'hA000_0002);
    bus_write(2'd0, 32'hA000_0003);
    bus_read(2'd1, rd);
    check("status_3", rd, 32'h0000_0300);
    check("head_3", out_data, 32'hA000_0001);
    out_ready = 1'b1;
    tick();
    check("drain_2", out_data, 32'hA000_0002);
    tick();
    check("drain_3", out_data, 32'hA000_0003);
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) bus_write(2'd0, 32'hC000_0000 + 32'(i));
    bus_read(2'd1, rd);
    check("status_full", rd, 32'h0000_1002);
    bus_read(2'd2, rd);
    check("overflow_set", rd, 32'd1);
    bus_write(2'd2, 32'd1);
    bus_read(2'd2, rd);
    check("overflow_clr", rd, 32'd0);
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && out_valid; i++) begin
      if (out_data == 32'hC000_0010) check("word17_seen", out_data, 32'hDEAD_DEAD);
      n++;
      tick();
    end
    check("overflow_pop_count", 32'(n), 32'd16);
    out_ready = 1'b0;

    // Push into a full FIFO while popping in the same cycle
    for (int i = 0; i < 16; i++) bus_write(2'd0, 32'hD000_0000 + 32'(i));
    out_ready = 1'b1;
    bus_write(2'd0, 32'hBEEF_0000);
    out_ready = 1'b0;
    bus_read(2'd1, rd);
    check("status_full_pushpop", rd, 32'h0000_1002);
    bus_read(2'd2, rd);
    check("no_overflow_pushpop", rd, 32'd0);
    out_ready = 1'b1;
    n   = 0;
    pos = 0;
    for (int i = 0; i < 40 && out_valid; i++) begin
      n++;
      if (out_data == 32'hBEEF_0000) pos = n;
      tick();
    end
    check("beef_position", 32'(pos), 32'd16);
    out_ready = 1'b0;

    // Flush
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'hE000_0000 + 32'(i));
    bus_write(2'd1, 32'd1);
    check("flush_valid", 32'(out_valid), 32'd0);
    bus_read(2'd1, rd);
    check("flush_status", rd, 32'h0000_0001);
    bus_write(2'd0, 32'h1234_5678);
    check("post_flush_head", out_data, 32'h1234_5678);
    bus_write(2'd1, 32'd1);

    // Three laps of 16 pushes / drains with random backpressure
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 16; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        bus_write(2'd0, $urandom);
      end
      for (int i = 0; i < 200 && model_q.size() != 0; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        address   = 2'($urandom_range(0, 3));
        tick();
      end
      check("lap_empty", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    bus_write(2'd2, 32'd1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) bus_write(2'd0, 32'hF000_0000 + 32'(i));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_readdata", readdata, 32'd0);
    model_q.delete();
    model_ovf = 1'b0;
    #2 reset_n = 1'b1;
    bus_read(2'd1, rd);
    check("status_after_async_reset", rd, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
